// File: rtl/jpeg_sof_seq.sv
// JPEG SOF0 segment sequencer: walks the frame header fields from a 64-bit peek window,
// requests consumption from the bit buffer and validates precision, component count and length.
module jpeg_sof_seq #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [3:0]  STATE_RST   = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        sof_start,
    input  logic        bit_avali,
    input  logic [63:0] bit_out,
    output logic [2:0]  sof_state,
    output logic        shift_en,
    output logic [6:0]  shift_num,
    output logic        sof_busy,
    output logic        sof_done,
    output logic        sof_err,
    output logic [2:0]  err_code,
    output logic [15:0] byte_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SIZE = 3'd1,
        S_RESO = 3'd2,
        S_Y    = 3'd3,
        S_CR   = 3'd4,
        S_CB   = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } sof_t;

    sof_t          cur;
    sof_t          nxt;
    logic [2:0]    nerr;
    logic [15:0]   len;
    logic [7:0]    prec;
    logic [7:0]    ncomp;
    logic          guard;
    logic [TW-1:0] tmo_cnt;

    logic          soft_rst;
    logic          in_field;
    logic          consume;
    logic          timeout;
    logic [6:0]    field_bits;
    logic [7:0]    res_prec;
    logic [7:0]    res_ncomp;
    logic [15:0]   res_len;

    assign soft_rst  = (state == STATE_RST);
    assign in_field  = cur inside {[S_SIZE:S_CB]};
    assign consume   = in_field && bit_avali && !guard && !soft_rst;
    assign timeout   = in_field && !bit_avali && !shift_en &&
                       (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign res_prec  = bit_out[63:56];
    assign res_ncomp = bit_out[23:16];
    assign res_len   = 16'd8 + 16'd3 * {8'd0, res_ncomp};
    assign sof_state = cur;

    always_comb begin
        unique case (cur)
            S_SIZE:  field_bits = 7'd16;
            S_RESO:  field_bits = 7'd48;
            S_Y,
            S_CR,
            S_CB:    field_bits = 7'd24;
            default: field_bits = 7'd0;
        endcase
    end

    // Next-state selection; the soft restart overrides everything, including a timeout.
    always_comb begin
        nxt  = cur;
        nerr = 3'd0;
        unique case (cur)
            S_IDLE: if (sof_start) nxt = S_SIZE;
            S_SIZE: if (consume) nxt = S_RESO;
            S_RESO: begin
                if (consume) begin
                    if (res_prec != 8'd8) begin
                        nxt  = S_ERR;
                        nerr = 3'd2;
                    end else if (res_ncomp != 8'd1 && res_ncomp != 8'd3) begin
                        nxt  = S_ERR;
                        nerr = 3'd3;
                    end else if (len != res_len) begin
                        nxt  = S_ERR;
                        nerr = 3'd1;
                    end else begin
                        nxt = S_Y;
                    end
                end
            end
            S_Y:    if (consume) nxt = (ncomp == 8'd3) ? S_CR : S_DONE;
            S_CR:   if (consume) nxt = S_CB;
            S_CB:   if (consume) nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            S_ERR:  nxt = S_ERR;
            default: nxt = S_IDLE;
        endcase
        if (timeout) begin
            nxt  = S_ERR;
            nerr = 3'd4;
        end
        if (soft_rst) begin
            nxt  = S_IDLE;
            nerr = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= S_IDLE;
            shift_en  <= 1'b0;
            shift_num <= 7'd0;
            sof_busy  <= 1'b0;
            sof_done  <= 1'b0;
            sof_err   <= 1'b0;
            err_code  <= 3'd0;
            byte_cnt  <= 16'd0;
            len       <= 16'd0;
            prec      <= 8'd0;
            ncomp     <= 8'd0;
            guard     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            cur      <= nxt;
            sof_busy <= nxt inside {[S_SIZE:S_CB]};
            sof_done <= (nxt == S_DONE);
            if (soft_rst) begin
                shift_en  <= 1'b0;
                shift_num <= 7'd0;
                guard     <= 1'b0;
                tmo_cnt   <= '0;
                byte_cnt  <= 16'd0;
                err_code  <= 3'd0;
                sof_err   <= 1'b0;
            end else begin
                // A consume cycle is always followed by one guard cycle so the buffer can refill.
                shift_en  <= consume;
                shift_num <= consume ? field_bits : 7'd0;
                guard     <= consume;
                if (consume) begin
                    byte_cnt <= byte_cnt + 16'(field_bits >> 3);
                end else if (cur == S_IDLE && sof_start) begin
                    byte_cnt <= 16'd0;
                end
                if (consume && cur == S_SIZE) begin
                    len <= bit_out[63:48];
                end
                if (consume && cur == S_RESO) begin
                    prec  <= res_prec;
                    ncomp <= res_ncomp;
                end
                if (nxt == S_ERR && cur != S_ERR) begin
                    sof_err  <= 1'b1;
                    err_code <= nerr;
                end
                if (nxt != cur || !in_field || shift_en) begin
                    tmo_cnt <= '0;
                end else if (!bit_avali) begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jpeg_sof_seq.sv
// Directed bench for jpeg_sof_seq: a byte-stream bit buffer model feeds bit_out, and a
// scoreboard of expected shift_num values is checked whenever the DUT requests a shift.
module tb_jpeg_sof_seq;

    localparam int         TIMEOUT_CYC = 1024;
    localparam logic [3:0] STATE_RST   = 4'd0;
    localparam logic [3:0] STATE_RUN   = 4'd5;
    localparam logic [2:0] S_IDLE = 3'd0, S_SIZE = 3'd1, S_Y = 3'd3, S_CR = 3'd4, S_ERR = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        sof_start;
    logic        bit_avali;
    logic [63:0] bit_out;
    logic [2:0]  sof_state;
    logic        shift_en;
    logic [6:0]  shift_num;
    logic        sof_busy;
    logic        sof_done;
    logic        sof_err;
    logic [2:0]  err_code;
    logic [15:0] byte_cnt;

    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];
    logic [7:0]  stream [0:255];
    logic [10:0] bptr = '0;
    logic        prev_en = 1'b0;
    logic [31:0] trace = '0;
    logic [2:0]  last_state = '0;

    always #5 clk = ~clk;

    jpeg_sof_seq #(.TIMEOUT_CYC(TIMEOUT_CYC), .STATE_RST(STATE_RST)) dut (
        .clk(clk), .rst(rst), .state(state), .sof_start(sof_start),
        .bit_avali(bit_avali), .bit_out(bit_out), .sof_state(sof_state),
        .shift_en(shift_en), .shift_num(shift_num), .sof_busy(sof_busy),
        .sof_done(sof_done), .sof_err(sof_err), .err_code(err_code), .byte_cnt(byte_cnt)
    );

    // Bit buffer model: window is the next eight stream bytes, advanced by each consume.
    always_comb begin
        bit_out = '0;
        for (int i = 0; i < 8; i++) begin
            bit_out[63 - 8*i -: 8] = stream[8'(int'(bptr[10:3]) + i)];
        end
    end

    always @(posedge clk) begin
        if (shift_en) bptr <= bptr + 11'(shift_num);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_err(input logic [15:0] l, input logic [7:0] p, input logic [7:0] nc);
        if (p != 8'd8) return 3'd2;
        if (nc != 8'd1 && nc != 8'd3) return 3'd3;
        if (l != 16'd8 + 16'd3 * {8'd0, nc}) return 3'd1;
        return 3'd0;
    endfunction

    // Scoreboard side: sampled 2 time units after the rising edge.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            if (shift_en) begin
                checkOutput("no_back_to_back", 32'(prev_en), 32'd0);
                if (exp_q.size() == 0)
                    checkOutput("shift_expected", 32'(shift_num), 32'd0);
                else
                    checkOutput("shift_num", 32'(shift_num), 32'(exp_q.pop_front()));
            end else begin
                checkOutput("shift_num_idle", 32'(shift_num), 32'd0);
            end
            if (sof_start && sof_state == S_SIZE) trace = '0;
            if (sof_state != last_state) trace = {trace[27:0], 1'b0, sof_state};
        end
        last_state = sof_state;
        prev_en    = shift_en;
    end

    task automatic applyStimulus(input logic [15:0] l, input logic [7:0] p, input logic [7:0] nc,
                                 input int max_fields);
        int         b = int'(bptr[10:3]);
        int         nf;
        logic [7:0] seg [0:16];
        seg = '{l[15:8], l[7:0], p, 8'h01, 8'hE0, 8'h02, 8'h80, nc,
                8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        for (int i = 0; i < 17; i++) stream[8'(b + i)] = seg[i];
        nf = (exp_err(l, p, nc) != 3'd0) ? 2 : ((nc == 8'd3) ? 5 : 3);
        if (max_fields < nf) nf = max_fields;
        for (int i = 0; i < nf; i++) exp_q.push_back((i == 0) ? 16 : ((i == 1) ? 48 : 24));
        sof_start = 1'b1;
        @(negedge clk);
        sof_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 100 && sof_state != s; i++) @(negedge clk);
        checkOutput(tag, 32'(sof_state), 32'(s));
    endtask

    task automatic check_segment_end(input logic [15:0] l, input logic [7:0] p, input logic [7:0] nc,
                                     input logic [31:0] exp_trace);
        logic [2:0] e = exp_err(l, p, nc);
        int         bytes = (e != 3'd0) ? 8 : ((nc == 8'd3) ? 17 : 11);
        for (int i = 0; i < 100 && !(sof_done || sof_err); i++) @(negedge clk);
        checkOutput("segment_end", 32'(sof_done | sof_err), 32'd1);
        checkOutput("sof_done", 32'(sof_done), 32'(e == 3'd0));
        checkOutput("sof_err", 32'(sof_err), 32'(e != 3'd0));
        checkOutput("err_code", 32'(err_code), 32'(e));
        checkOutput("byte_cnt", 32'(byte_cnt), 32'(bytes));
        checkOutput("sof_busy_end", 32'(sof_busy), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        if (e == 3'd0) begin
            checkOutput("state_after_done", 32'(sof_state), 32'(S_IDLE));
            checkOutput("done_pulse_width", 32'(sof_done), 32'd0);
            checkOutput("state_trace", trace, exp_trace);
        end else begin
            checkOutput("err_state_hold", 32'(sof_state), 32'(S_ERR));
            checkOutput("err_flag_hold", 32'(sof_err), 32'd1);
        end
    endtask

    task automatic soft_restart();
        state = STATE_RST;
        @(negedge clk);
        state = STATE_RUN;
        checkOutput("restart_state", 32'(sof_state), 32'(S_IDLE));
        checkOutput("restart_err", 32'(sof_err), 32'd0);
        checkOutput("restart_code", 32'(err_code), 32'd0);
        checkOutput("restart_bytes", 32'(byte_cnt), 32'd0);
        checkOutput("restart_shift", 32'(shift_en), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_state"}, 32'(sof_state), 32'd0);
        checkOutput({tag, "_shift_en"}, 32'(shift_en), 32'd0);
        checkOutput({tag, "_shift_num"}, 32'(shift_num), 32'd0);
        checkOutput({tag, "_busy"}, 32'(sof_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(sof_done), 32'd0);
        checkOutput({tag, "_err"}, 32'(sof_err), 32'd0);
        checkOutput({tag, "_code"}, 32'(err_code), 32'd0);
        checkOutput({tag, "_bytes"}, 32'(byte_cnt), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        state     = STATE_RUN;
        sof_start = 1'b0;
        bit_avali = 1'b1;
        for (int i = 0; i < 256; i++) stream[i] = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] colour SOF with a stray sof_start mid-segment");
        applyStimulus(16'd17, 8'd8, 8'd3, 5);
        checkOutput("busy_in_size", 32'(sof_busy), 32'd1);
        wait_state(S_Y, "reach_y");
        sof_start = 1'b1;
        @(negedge clk);
        sof_start = 1'b0;
        check_segment_end(16'd17, 8'd8, 8'd3, 32'h0123_4560);

        $display("[TB] grey SOF");
        applyStimulus(16'd11, 8'd8, 8'd1, 5);
        check_segment_end(16'd11, 8'd8, 8'd1, 32'h0001_2360);

        $display("[TB] bad precision, bad length, bad component count");
        applyStimulus(16'd17, 8'd12, 8'd3, 5);
        check_segment_end(16'd17, 8'd12, 8'd3, 32'h0);
        soft_restart();
        applyStimulus(16'd14, 8'd8, 8'd3, 5);
        check_segment_end(16'd14, 8'd8, 8'd3, 32'h0);
        soft_restart();
        applyStimulus(16'd14, 8'd8, 8'd2, 5);
        check_segment_end(16'd14, 8'd8, 8'd2, 32'h0);
        soft_restart();

        $display("[TB] soft restart outranks sof_start");
        state     = STATE_RST;
        sof_start = 1'b1;
        @(negedge clk);
        state     = STATE_RUN;
        sof_start = 1'b0;
        checkOutput("rst_beats_start", 32'(sof_state), 32'(S_IDLE));
        @(negedge clk);
        checkOutput("rst_beats_start_hold", 32'(sof_state), 32'(S_IDLE));

        $display("[TB] input gap one cycle short of the timeout");
        applyStimulus(16'd17, 8'd8, 8'd3, 5);
        wait_state(S_CR, "reach_cr_gap");
        @(negedge clk);
        bit_avali = 1'b0;
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        checkOutput("no_early_timeout", 32'(sof_err), 32'd0);
        checkOutput("still_cr", 32'(sof_state), 32'(S_CR));
        bit_avali = 1'b1;
        check_segment_end(16'd17, 8'd8, 8'd3, 32'h0123_4560);

        $display("[TB] input gap reaching the timeout");
        applyStimulus(16'd17, 8'd8, 8'd3, 3);
        wait_state(S_CR, "reach_cr_tmo");
        @(negedge clk);
        bit_avali = 1'b0;
        repeat (TIMEOUT_CYC) @(negedge clk);
        checkOutput("timeout_state", 32'(sof_state), 32'(S_ERR));
        checkOutput("timeout_err", 32'(sof_err), 32'd1);
        checkOutput("timeout_code", 32'(err_code), 32'd4);
        checkOutput("timeout_bytes", 32'(byte_cnt), 32'd11);
        bit_avali = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("timeout_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("timeout_err_hold", 32'(sof_err), 32'd1);
        soft_restart();

        $display("[TB] async reset while in Y, then a fresh colour SOF");
        applyStimulus(16'd17, 8'd8, 8'd3, 5);
        wait_state(S_Y, "reach_y_rst");
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(16'd17, 8'd8, 8'd3, 5);
        check_segment_end(16'd17, 8'd8, 8'd3, 32'h0123_4560);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
